// File: rtl/sigma_delta_dac.sv
// Single-bit sigma-delta DAC.
// PCM samples arrive at clk / OVERSAMPLE_RATE through a one-deep valid/ready
// buffer. They are optionally linearly interpolated, then drive a first- or
// second-order modulator whose registered bitstream leaves on dac_pin for an
// external RC low-pass. All datapath math is offset binary.

module sigma_delta_dac #(
    parameter int OVERSAMPLE_RATE = 256,
    parameter int DAC_BITLEN      = 16,
    parameter int SIGNED_INPUT    = 1,
    parameter int MOD_ORDER       = 2,
    parameter int USE_INTERP      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DAC_BITLEN-1:0] dac_input,
    input  logic                  dac_valid,
    output logic                  dac_ready,
    output logic                  dac_pin,
    output logic                  underrun
);

    localparam int N  = DAC_BITLEN;
    localparam int L  = $clog2(OVERSAMPLE_RATE);
    localparam int IW = N + L + 1;
    localparam int MW = N + 4;

    localparam logic [N-1:0]           MIDSCALE = {1'b1, {(N-1){1'b0}}};
    localparam logic [L-1:0]           OSR_LAST = L'(OVERSAMPLE_RATE - 1);
    localparam logic signed [MW+1:0]   FB_HI    = (MW+2)'(2 ** N);
    localparam logic signed [MW+1:0]   SAT_MAX  = (MW+2)'(2 ** (MW - 1) - 1);
    localparam logic signed [MW+1:0]   SAT_MIN  = -SAT_MAX - (MW+2)'(1);

    logic [L-1:0] osr_cnt;
    logic         tick;
    logic [N-1:0] u;
    logic         accept;
    logic         buf_full;
    logic [N-1:0] buf_q;
    logic [N-1:0] prev_q;
    logic [N-1:0] cur_q;
    logic [N-1:0] cur_nxt;
    logic [N-1:0] x;

    // Clamp a widened integrator sum back into the integrator's signed range.
    function automatic logic signed [MW-1:0] sat(input logic signed [MW+1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[MW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[MW-1:0];
        end
        return v[MW-1:0];
    endfunction

    assign tick      = (osr_cnt == OSR_LAST);
    // Flipping the MSB turns two's complement into offset binary.
    assign u         = (SIGNED_INPUT != 0) ? (dac_input ^ MIDSCALE) : dac_input;
    assign accept    = dac_valid & ~buf_full;
    assign dac_ready = ~buf_full;
    assign cur_nxt   = buf_full ? buf_q : cur_q;

    // Sample-rate counter, one-deep input buffer and prev/cur sample pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osr_cnt  <= '0;
            buf_full <= 1'b0;
            buf_q    <= '0;
            prev_q   <= MIDSCALE;
            cur_q    <= MIDSCALE;
            underrun <= 1'b0;
        end else begin
            osr_cnt <= osr_cnt + 1'b1;
            if (tick) begin
                prev_q   <= cur_q;
                cur_q    <= cur_nxt;
                underrun <= ~buf_full;
            end
            // A sample accepted on an empty-buffer tick waits for the next tick.
            if (accept) begin
                buf_q    <= u;
                buf_full <= 1'b1;
            end else if (tick) begin
                buf_full <= 1'b0;
            end
        end
    end

    generate
        if (USE_INTERP != 0) begin : g_interp
            logic signed [IW-1:0] ia;
            logic signed [N:0]    slope;
            logic signed [N:0]    slope_tick;
            logic [N:0]           ia_hi;

            assign slope      = $signed({1'b0, cur_q}) - $signed({1'b0, prev_q});
            assign slope_tick = $signed({1'b0, cur_nxt}) - $signed({1'b0, cur_q});
            assign ia_hi      = ia[IW-1:L];

            // Ramp accumulator: the tick load already includes the first step,
            // so x lands exactly on the new sample on the last clock of the period.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ia <= $signed({1'b0, MIDSCALE, {L{1'b0}}});
                end else if (tick) begin
                    ia <= $signed({1'b0, cur_q, {L{1'b0}}}) + IW'(slope_tick);
                end else begin
                    ia <= ia + IW'(slope);
                end
            end

            // ia >> L cannot exceed 2^N-1, so only negative excursions need clamping.
            always_comb begin
                x = ia_hi[N-1:0];
                if (ia_hi[N]) begin
                    x = '0;
                end
            end
        end else begin : g_zoh
            // Zero-order hold straight from the current sample.
            always_comb begin
                x = cur_q;
            end
        end
    endgenerate

    generate
        if (MOD_ORDER == 1) begin : g_mod1
            logic [N-1:0] a1;

            // First-order modulator: the accumulator carry is the bitstream.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a1      <= '0;
                    dac_pin <= 1'b0;
                end else begin
                    {dac_pin, a1} <= {1'b0, a1} + {1'b0, x};
                end
            end
        end else begin : g_mod2
            logic signed [MW+1:0] fb;
            logic signed [MW+1:0] i1_sum;
            logic signed [MW+1:0] i2_sum;
            logic signed [MW-1:0] i1;
            logic signed [MW-1:0] i2;
            logic signed [MW-1:0] i1_nxt;
            logic signed [MW-1:0] i2_nxt;

            // The second integrator takes the freshly updated i1 and the pin is
            // the sign of the updated i2, giving NTF = (1 - z^-1)^2.
            assign fb     = dac_pin ? FB_HI : '0;
            assign i1_sum = (MW+2)'(i1) + $signed({{(MW+2-N){1'b0}}, x}) - fb;
            assign i1_nxt = sat(i1_sum);
            assign i2_sum = (MW+2)'(i2) + (MW+2)'(i1_nxt) - fb;
            assign i2_nxt = sat(i2_sum);

            // Second-order modulator state and registered comparator.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    i1      <= '0;
                    i2      <= '0;
                    dac_pin <= 1'b0;
                end else begin
                    i1      <= i1_nxt;
                    i2      <= i2_nxt;
                    dac_pin <= ~i2_nxt[MW-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Directed bench for sigma_delta_dac. Three instances share clock and reset:
// dut_a (1st order, hold), dut_b (1st order, interpolating), dut_c (2nd order,
// interpolating). Inputs change on the falling edge, outputs are read there too.

module tb_sigma_delta_dac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_a, in_b, in_c;
    logic        v_a, v_b, v_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic        pin_a, pin_b, pin_c;
    logic        und_a, und_b, und_c;

    int checks = 0;
    int passed = 0;
    int e      = 0;

    always #5 clk = ~clk;

    sigma_delta_dac #(.OVERSAMPLE_RATE(256), .DAC_BITLEN(16), .SIGNED_INPUT(1),
                      .MOD_ORDER(1), .USE_INTERP(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .dac_input(in_a), .dac_valid(v_a),
        .dac_ready(rdy_a), .dac_pin(pin_a), .underrun(und_a));

    sigma_delta_dac #(.OVERSAMPLE_RATE(256), .DAC_BITLEN(16), .SIGNED_INPUT(1),
                      .MOD_ORDER(1), .USE_INTERP(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .dac_input(in_b), .dac_valid(v_b),
        .dac_ready(rdy_b), .dac_pin(pin_b), .underrun(und_b));

    sigma_delta_dac #(.OVERSAMPLE_RATE(256), .DAC_BITLEN(16), .SIGNED_INPUT(1),
                      .MOD_ORDER(2), .USE_INTERP(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .dac_input(in_c), .dac_valid(v_c),
        .dac_ready(rdy_c), .dac_pin(pin_c), .underrun(und_c));

    task automatic step();
        @(negedge clk);
        e++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
        in_a = '0;  in_b = '0;  in_c = '0;
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
        in_a = '0;  in_b = '0;  in_c = '0;
        #2;
        checks++;
        if ({pin_a, rdy_a, und_a} !== 3'b010)
            $display("FAIL reset_a: pin/ready/underrun=%b expected 010", {pin_a, rdy_a, und_a});
        else passed++;
        checks++;
        if ({pin_b, rdy_b, und_b} !== 3'b010)
            $display("FAIL reset_b: pin/ready/underrun=%b expected 010", {pin_b, rdy_b, und_b});
        else passed++;
        checks++;
        if ({pin_c, rdy_c, und_c} !== 3'b010)
            $display("FAIL reset_c: pin/ready/underrun=%b expected 010", {pin_c, rdy_c, und_c});
        else passed++;
    endtask

    task automatic test_idle();
        int ones = 0;
        int pat_err = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step();
            if (pin_a !== ((e % 2) == 0)) pat_err++;
            ones += int'(pin_a);
            if (e == 255) begin
                checks++;
                if (und_a !== 1'b0) $display("FAIL idle_underrun_early: got %b expected 0", und_a);
                else passed++;
            end
        end
        checks++;
        if (und_a !== 1'b1) $display("FAIL idle_underrun_tick: got %b expected 1", und_a);
        else passed++;
        checks++;
        if (rdy_a !== 1'b1) $display("FAIL idle_ready: got %b expected 1", rdy_a);
        else passed++;
        checks++;
        if (pat_err != 0) $display("FAIL idle_toggle: %0d bits off the 0,1,0,1 pattern, expected 0", pat_err);
        else passed++;
        checks++;
        if (ones != 128) $display("FAIL idle_density: got %0d ones expected 128", ones);
        else passed++;
    endtask

    task automatic test_const();
        int ones = 0;
        do_reset();
        in_a = 16'h4000;
        v_a  = 1'b1;
        while (e < 512) begin
            step();
            if (e > 256) ones += int'(pin_a);
        end
        checks++;
        if (ones != 192) $display("FAIL const_0x4000: got %0d ones expected 192", ones);
        else passed++;

        ones = 0;
        do_reset();
        in_a = 16'h8000;
        v_a  = 1'b1;
        while (e < 512) begin
            step();
            if (e > 256) ones += int'(pin_a);
        end
        checks++;
        if (ones != 0) $display("FAIL const_neg_fs: got %0d ones expected 0", ones);
        else passed++;
    endtask

    logic [15:0] hs_q[$];

    task automatic test_handshake();
        logic [15:0] data  = 16'h0010;
        logic [15:0] cur_m = 16'h8000;
        logic        bf_m  = 1'b0;
        int          osr_m = 0;
        int          err_rdy = 0;
        int          err_cur = 0;
        logic        acc, tk;
        hs_q.delete();
        do_reset();
        v_a = 1'b1;
        for (int i = 0; i < 6 * 256; i++) begin
            in_a = data;
            acc  = v_a && !bf_m;
            tk   = (osr_m == 255);
            step();
            if (tk && bf_m) cur_m = hs_q.pop_front();
            if (acc) begin
                hs_q.push_back(data ^ 16'h8000);
                data = data + 16'h1111;
                bf_m = 1'b1;
            end else if (tk) begin
                bf_m = 1'b0;
            end
            osr_m = (osr_m + 1) % 256;
            if (rdy_a !== !bf_m) begin
                if (err_rdy == 0) $display("FAIL hs_ready at edge %0d: got %b expected %b", e, rdy_a, !bf_m);
                err_rdy++;
            end
            if (dut_a.cur_q !== cur_m) begin
                if (err_cur == 0) $display("FAIL hs_cur at edge %0d: got %h expected %h", e, dut_a.cur_q, cur_m);
                err_cur++;
            end
        end
        checks++;
        if (err_rdy != 0) $display("FAIL hs_ready_total: %0d ready mismatches, expected 0", err_rdy);
        else passed++;
        checks++;
        if (err_cur != 0) $display("FAIL hs_cur_total: %0d sample mismatches, expected 0", err_cur);
        else passed++;
        checks++;
        if (dut_a.cur_q !== 16'hD565) $display("FAIL hs_sixth_sample: got %h expected d565", dut_a.cur_q);
        else passed++;
    endtask

    task automatic test_underrun();
        int ones = 0;
        do_reset();
        in_a = 16'h4000;
        while (e < 1792) begin
            v_a = ((e + 1) <= 513) || ((e + 1) > 1536);
            step();
            if (e > 1024 && e <= 1280) ones += int'(pin_a);
            if (e == 768) begin
                checks++;
                if (und_a !== 1'b0) $display("FAIL ur_tick3: got %b expected 0", und_a);
                else passed++;
            end
            if (e == 1024) begin
                checks++;
                if (und_a !== 1'b1) $display("FAIL ur_first_miss: got %b expected 1", und_a);
                else passed++;
            end
            if (e == 1536) begin
                checks++;
                if ({und_a, rdy_a} !== 2'b11) $display("FAIL ur_third_miss: underrun/ready=%b expected 11", {und_a, rdy_a});
                else passed++;
            end
            if (e == 1537) begin
                checks++;
                if (rdy_a !== 1'b0) $display("FAIL ur_resume_accept: ready=%b expected 0", rdy_a);
                else passed++;
            end
        end
        checks++;
        if (und_a !== 1'b0) $display("FAIL ur_clear: got %b expected 0", und_a);
        else passed++;
        checks++;
        if (ones != 192) $display("FAIL ur_hold_density: got %0d ones expected 192", ones);
        else passed++;
    endtask

    task automatic test_interp();
        int          ramp_err = 0;
        int          step_err = 0;
        int          exp_x;
        logic [15:0] last_x = '0;
        do_reset();
        in_b = 16'h8000;
        v_b  = 1'b1;
        while (e < 768) begin
            if (e >= 1) in_b = 16'h7FFF;
            step();
            if (e == 255) begin
                checks++;
                if (dut_b.x !== 16'h8000) $display("FAIL interp_mid: got %h expected 8000", dut_b.x);
                else passed++;
            end
            if (e == 256) begin
                checks++;
                if (dut_b.x !== 16'h7F80) $display("FAIL interp_down_first: got %h expected 7f80", dut_b.x);
                else passed++;
            end
            if (e == 511) begin
                checks++;
                if (dut_b.x !== 16'h0000) $display("FAIL interp_down_end: got %h expected 0000", dut_b.x);
                else passed++;
            end
            if (e >= 512 && e < 768) begin
                exp_x = ((e - 511) * 65535) >> 8;
                if (int'(dut_b.x) != exp_x) begin
                    if (ramp_err == 0) $display("FAIL interp_ramp at edge %0d: got %h expected %h", e, dut_b.x, exp_x);
                    ramp_err++;
                end
                if (e > 512 && (dut_b.x - last_x) != 16'h00FF && (dut_b.x - last_x) != 16'h0100) step_err++;
                if (e == 512) begin
                    checks++;
                    if (dut_b.x !== 16'h00FF) $display("FAIL interp_up_first: got %h expected 00ff", dut_b.x);
                    else passed++;
                end
            end
            last_x = dut_b.x;
        end
        checks++;
        if (dut_b.x !== 16'hFFFF) $display("FAIL interp_up_end: got %h expected ffff", dut_b.x);
        else passed++;
        checks++;
        if (ramp_err != 0) $display("FAIL interp_ramp_total: %0d mismatches, expected 0", ramp_err);
        else passed++;
        checks++;
        if (step_err != 0) $display("FAIL interp_step: %0d steps outside ff/100, expected 0", step_err);
        else passed++;
    endtask

    task automatic test_mod2();
        logic [15:0] lvl [3] = '{16'h4000, 16'hC000, 16'h0000};
        int          expd[3] = '{768, 256, 512};
        int          ones;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            in_c = lvl[k];
            v_c  = 1'b1;
            ones = 0;
            while (e < 1792) begin
                step();
                if (e > 768) ones += int'(pin_c);
            end
            checks++;
            if ((ones - expd[k]) > 10 || (expd[k] - ones) > 10)
                $display("FAIL mod2_level_%0d: got %0d ones in 1024 expected %0d +/-10", k, ones, expd[k]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_c = 16'h4000;
        v_c  = 1'b1;
        while (e < 300) step();
        checks++;
        if ({und_a, rdy_c} !== 2'b10) $display("FAIL ar_pre: underrun_a/ready_c=%b expected 10", {und_a, rdy_c});
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pin_c, rdy_c, und_c, pin_a, rdy_a, und_a} !== 6'b010010)
            $display("FAIL ar_immediate: pins/ready/underrun=%b expected 010010",
                     {pin_c, rdy_c, und_c, pin_a, rdy_a, und_a});
        else passed++;
        repeat (3) @(negedge clk);
        v_c   = 1'b0;
        rst_n = 1'b1;
        e     = 0;
        while (e < 256) step();
        checks++;
        if (und_c !== 1'b1) $display("FAIL ar_discard_underrun: got %b expected 1", und_c);
        else passed++;
        checks++;
        if (dut_c.cur_q !== 16'h8000) $display("FAIL ar_discard_cur: got %h expected 8000", dut_c.cur_q);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_const();
        test_handshake();
        test_underrun();
        test_interp();
        test_mod2();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
